hamming_decoder_15_11: RTL and testbench
========================================

Name: hamming_decoder_15_11

Overview:
Serial Hamming(15,11) decoder and the receive-side counterpart of the encoder datapath. It collects 15-bit codewords one bit per qualified cycle, computes the 4-bit syndrome, and corrects any single-bit error. It then re-serialises the 11 corrected data bits MSB first. It runs on one clock, and input and output are paced by strobes instead of divided clocks.

Parameters:
CNT_W, 8, width of the corrected-error counter (used only when HAMMING_ERR_CNT_EN is defined)

Ports:
CLK  input  1  single system clock; all state updates on the rising edge
REST  input  1  reset, synchronous, active-low
DEVICE_EN  input  1  global enable; when low, all internal state and outputs hold
IN_VALID  input  1  SERIAL_IN carries a codeword bit this cycle
SERIAL_IN  input  1  codeword bit; order is c15 first, c1 last
OUT_EN  input  1  consumer takes SERIAL_OUT this cycle
SERIAL_OUT  output  1  corrected data bit; order is d10 first, d0 last
OUT_VALID  output  1  SERIAL_OUT holds an untaken data bit
ERR_CORR  output  1  one-cycle pulse: the decoded frame had a nonzero syndrome
SYNDROME  output  4  syndrome of the last decoded frame; held until the next decode
OVERRUN  output  1  sticky flag: a decoded frame replaced undelivered data
ERR_CNT  output  CNT_W  corrected-frame count (present only with HAMMING_ERR_CNT_EN)

Behaviour:
- Reset (REST=0 at an edge) sets: SERIAL_OUT=0, OUT_VALID=0, ERR_CORR=0, SYNDROME=0, OVERRUN=0, ERR_CNT=0, input bit counter=0, output bit counter=0, both shift registers=0. Reset takes priority over DEVICE_EN.
- Mid-frame reset discards the partial codeword and any undelivered data.
- Code layout:
  - Positions 1..15. Parity bits sit at positions 1, 2, 4 and 8. Data bits d10..d0 fill positions 15,14,13,12,11,10,9,7,6,5,3 in that order.
  - Parity is even. Parity bit pk covers every position whose index has bit k set.
- Input collector:
  - On each edge with DEVICE_EN=1 and IN_VALID=1, SERIAL_IN shifts into a 15-bit register and a 0..14 counter increments.
  - The counter wraps 14→0 on the 15th bit.
  - IN_VALID=0 leaves the collector unchanged. Gaps between bits are allowed.
- Decode happens combinationally on the completed word and is registered on the edge that samples the 15th bit:
  - SYNDROME is the XOR of the indices of all 1-bits (positions 1..15).
  - Nonzero syndrome: flip the bit at that position, then set ERR_CORR=1 for exactly one cycle.
  - Zero syndrome: pass the word through unchanged.
  - The 11 data bits load into the output shift register. OUT_VALID=1 and SERIAL_OUT=d10 from the next cycle.
  - Latency is one edge from the 15th input bit to the first output bit.
  - A double-bit error is mis-corrected; that is inherent to the code and no flag is raised for it.
- Output serialiser, states IDLE (OUT_VALID=0) and SHIFT (OUT_VALID=1):
  - In SHIFT, each edge with DEVICE_EN=1 and OUT_EN=1 advances one bit.
  - After the 11th accepted bit the state returns to IDLE, OUT_VALID=0 and SERIAL_OUT=0.
  - OUT_EN in IDLE is ignored.
- Simultaneous events:
  - Decode load on the same edge as the 11th accepted bit: the load wins and OVERRUN stays clear.
  - Decode load while OUT_VALID=1 and the current edge is not the final shift: the new frame overwrites, the output counter restarts, and OVERRUN sets and stays set until reset.
- DEVICE_EN=0 freezes everything:
  - Collector, serialiser and flags hold.
  - ERR_CORR holds its value and does not re-pulse.
  - IN_VALID and OUT_EN are ignored while DEVICE_EN=0.

Optional Feature:
HAMMING_ERR_CNT_EN
- Defined: the ERR_CNT port exists. It increments on every decode with a nonzero syndrome and saturates at all-ones (no wrap). Reset clears it.
- Undefined: the port, register and increment logic are absent. All other behaviour is identical.

Test Plan:
- Clean frame: reset, then stream codeword 0x75A7 (c15..c1 = 111010110100111) with IN_VALID=1 and OUT_EN=1 continuously. Required response: OUT_VALID high for 11 cycles starting one edge after bit 15, output 11101010101, SYNDROME=0, ERR_CORR never pulses.
- Single error: same frame with c6 flipped (0x7587). Required response: SYNDROME=6, ERR_CORR high for exactly one cycle, output 11101010101. Repeat the flip for every position 1..15 and require SYNDROME equal to that position with correct data each time.
- Back-to-back frames with random IN_VALID gaps: three frames carrying data 11101010101, 10011101110 and 01100110011. Required response: all three delivered in order and OVERRUN=0.
- Overrun: hold OUT_EN=0 until the second frame completes. Required response: OVERRUN=1 and stays 1, SERIAL_OUT streams only the second frame's data. Also align the second frame's load with the 11th accepted bit of the first frame and require OVERRUN=0.
- Enable and reset: drop DEVICE_EN for 5 cycles mid-frame. Required response: state holds and the frame completes correctly after re-enable. Assert REST=0 after 7 bits. Required response: all outputs 0, and the next full frame decodes correctly.
- With HAMMING_ERR_CNT_EN and CNT_W=2: send 5 errored frames. Required response: ERR_CNT reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/hamming_decoder_15_11.sv
// Serial Hamming(15,11) decoder: collects codeword bits, corrects single-bit errors, re-serialises data MSB first.
// Optional corrected-frame counter ERR_CNT is built only when HAMMING_ERR_CNT_EN is defined.
module hamming_decoder_15_11 #(
  parameter int CNT_W = 8
) (
  input  logic       CLK,
  input  logic       REST,
  input  logic       DEVICE_EN,
  input  logic       IN_VALID,
  input  logic       SERIAL_IN,
  input  logic       OUT_EN,
  output logic       SERIAL_OUT,
  output logic       OUT_VALID,
  output logic       ERR_CORR,
  output logic [3:0] SYNDROME,
  output logic       OVERRUN
`ifdef HAMMING_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] ERR_CNT
`endif
);

  // Handshake: an output bit moves on an edge with DEVICE_EN=1, OUT_VALID=1 and OUT_EN=1;
  // an input bit is taken on an edge with DEVICE_EN=1 and IN_VALID=1. Nothing else moves data.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]  state;
  logic [13:0] in_sr;
  logic [3:0]  in_cnt;
  logic [10:0] out_sr;
  logic [3:0]  out_cnt;

  logic [14:0] word;
  logic [14:0] fixed;
  logic [3:0]  syn;
  logic [10:0] data;
  logic        load;
  logic        last_shift;

  // The 15th bit is decoded live from SERIAL_IN, so only 14 bits need storing.
  always_comb begin
    word = {in_sr, SERIAL_IN};
    syn  = 4'd0;
    for (int p = 1; p <= 15; p++) begin
      if (word[p-1]) syn = syn ^ 4'(p);
    end
    fixed = word;
    if (syn != 4'd0) fixed = word ^ (15'd1 << (syn - 4'd1));
    data = {fixed[14:8], fixed[6:4], fixed[2]};
  end

  assign load       = DEVICE_EN && IN_VALID && (in_cnt == 4'd14);
  assign last_shift = DEVICE_EN && (state == SHIFT) && OUT_EN && (out_cnt == 4'd10);
  assign OUT_VALID  = state;
  assign SERIAL_OUT = out_sr[10];

  always_ff @(posedge CLK) begin
    if (!REST) begin
      state    <= IDLE;
      in_sr    <= '0;
      in_cnt   <= '0;
      out_sr   <= '0;
      out_cnt  <= '0;
      ERR_CORR <= 1'b0;
      SYNDROME <= '0;
      OVERRUN  <= 1'b0;
    end else if (DEVICE_EN) begin
      if (IN_VALID) begin
        in_sr  <= {in_sr[12:0], SERIAL_IN};
        in_cnt <= (in_cnt == 4'd14) ? 4'd0 : in_cnt + 4'd1;
      end
      ERR_CORR <= load && (syn != 4'd0);
      if (load) begin
        SYNDROME <= syn;
        out_sr   <= data;
        out_cnt  <= '0;
        state    <= SHIFT;
        // Replacing a frame mid-delivery is an overrun; landing on its final bit is not.
        if ((state == SHIFT) && !last_shift) OVERRUN <= 1'b1;
      end else if ((state == SHIFT) && OUT_EN) begin
        out_sr <= {out_sr[9:0], 1'b0};
        if (out_cnt == 4'd10) begin
          state   <= IDLE;
          out_cnt <= '0;
        end else begin
          out_cnt <= out_cnt + 4'd1;
        end
      end
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  // Saturating count of frames that needed correction.
  always_ff @(posedge CLK) begin
    if (!REST) begin
      ERR_CNT <= '0;
    end else if (load && (syn != 4'd0) && (ERR_CNT != {CNT_W{1'b1}})) begin
      ERR_CNT <= ERR_CNT + CNT_W'(1);
    end
  end
`else
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hamming_decoder_15_11.sv
// Directed bench for hamming_decoder_15_11: clean/errored frames, gaps, overrun, enable freeze, reset.
// Define HAMMING_ERR_CNT_EN to also exercise the saturating ERR_CNT with CNT_W=2.
module tb_hamming_decoder_15_11;

`ifdef HAMMING_ERR_CNT_EN
  localparam int CNT_W = 2;
  logic [CNT_W-1:0] err_cnt;
`else
  localparam int CNT_W = 8;
`endif

  localparam logic [10:0] D1 = 11'b11101010101;
  localparam logic [10:0] D2 = 11'b10011101110;
  localparam logic [10:0] D3 = 11'b01100110011;
  localparam logic [14:0] CW1 = 15'h75A7;

  logic       clk = 1'b0;
  logic       rest = 1'b0;
  logic       dev_en = 1'b1;
  logic       in_valid = 1'b0;
  logic       serial_in = 1'b0;
  logic       out_en = 1'b0;
  logic       serial_out;
  logic       out_valid;
  logic       err_corr;
  logic [3:0] syndrome;
  logic       overrun;

  int n_checks = 0;
  int n_err = 0;
  int ec_cycles = 0;
  int ov_cycles = 0;
  int ncol = 0;
  logic [10:0] col = '0;
  logic [10:0] exp_q[$];

  hamming_decoder_15_11 #(.CNT_W(CNT_W)) dut (
    .CLK(clk),
    .REST(rest),
    .DEVICE_EN(dev_en),
    .IN_VALID(in_valid),
    .SERIAL_IN(serial_in),
    .OUT_EN(out_en),
    .SERIAL_OUT(serial_out),
    .OUT_VALID(out_valid),
    .ERR_CORR(err_corr),
    .SYNDROME(syndrome),
    .OVERRUN(overrun)
`ifdef HAMMING_ERR_CNT_EN
    ,
    .ERR_CNT(err_cnt)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Encoder used only to build stimulus codewords.
  function automatic logic [14:0] enc(input logic [10:0] d);
    logic [14:0] w;
    logic par;
    w = '0;
    w[14:8] = d[10:4];
    w[6:4]  = d[3:1];
    w[2]    = d[0];
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 15; p++) begin
        if ((p & (1 << k)) != 0) par = par ^ w[p-1];
      end
      w[(1 << k) - 1] = par;
    end
    return w;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rest = 1'b0;
    tick();
    rest = 1'b1;
  endtask

  task automatic send_range(input logic [14:0] w, input int hi, input int lo, input int maxgap);
    for (int i = hi; i >= lo; i--) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      in_valid = 1'b0;
      repeat (g) tick();
      in_valid  = 1'b1;
      serial_in = w[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      tick();
      t++;
    end
    check("drain_timeout", (t < 300), 1);
  endtask

  // Scoreboard: sample at negedge what the next rising edge will accept.
  always @(negedge clk) begin
    if (!rest) begin
      ncol = 0;
    end else if (dev_en) begin
      if (err_corr) ec_cycles++;
      if (out_valid) ov_cycles++;
      if (out_valid && out_en) begin
        col = {col[9:0], serial_out};
        ncol++;
        if (ncol == 11) begin
          if (exp_q.size() == 0) check("extra_frame", col, 11'h7FF ^ col);
          else check("frame_data", col, exp_q.pop_front());
          ncol = 0;
        end
      end
    end
  end

  initial begin
    logic [14:0] w;
    tick();
    tick();
    rest = 1'b1;
    check("rst_serial_out", serial_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_corr", err_corr, 0);
    check("rst_syndrome", syndrome, 0);
    check("rst_overrun", overrun, 0);
`ifdef HAMMING_ERR_CNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif

    // Clean frame, continuous strobes
    ov_cycles = 0;
    ec_cycles = 0;
    out_en = 1'b1;
    exp_q.push_back(D1);
    send_range(CW1, 14, 1, 0);
    check("pre_valid", out_valid, 0);
    send_range(CW1, 0, 0, 0);
    check("lat_valid", out_valid, 1);
    check("lat_first_bit", serial_out, 1);
    check("clean_syndrome", syndrome, 0);
    check("clean_err_corr", err_corr, 0);
    drain();
    check("clean_valid_cycles", ov_cycles, 11);
    check("clean_no_pulse", ec_cycles, 0);

    // Single-bit error at every position
    ec_cycles = 0;
    for (int p = 1; p <= 15; p++) begin
      w = CW1 ^ (15'd1 << (p - 1));
      exp_q.push_back(D1);
      send_range(w, 14, 0, 0);
      check("err_syndrome", syndrome, p);
      check("err_pulse", err_corr, 1);
      tick();
      check("err_pulse_end", err_corr, 0);
      drain();
    end
    check("err_pulse_total", ec_cycles, 15);

    // Back-to-back frames with random gaps
    exp_q.push_back(D1);
    exp_q.push_back(D2);
    exp_q.push_back(D3);
    send_range(enc(D1), 14, 0, 3);
    send_range(enc(D2), 14, 0, 3);
    send_range(enc(D3), 14, 0, 3);
    drain();
    check("b2b_overrun", overrun, 0);

    // Overrun: first frame never taken
    out_en = 1'b0;
    send_range(enc(D1), 14, 0, 0);
    exp_q.push_back(D2);
    send_range(enc(D2), 14, 0, 0);
    check("ovr_set", overrun, 1);
    check("ovr_valid", out_valid, 1);
    out_en = 1'b1;
    drain();
    check("ovr_sticky", overrun, 1);

    // Load coinciding with the 11th accepted bit is not an overrun
    do_reset();
    check("ovr_cleared", overrun, 0);
    out_en = 1'b0;
    exp_q.push_back(D1);
    exp_q.push_back(D2);
    send_range(enc(D1), 14, 0, 0);
    fork
      send_range(enc(D2), 14, 0, 0);
      begin
        repeat (4) tick();
        out_en = 1'b1;
      end
    join
    check("align_overrun", overrun, 0);
    check("align_valid", out_valid, 1);
    check("align_first_bit", serial_out, D2[10]);
    drain();
    check("align_overrun_end", overrun, 0);

    // Enable freeze mid-frame
    out_en = 1'b1;
    exp_q.push_back(D3);
    send_range(enc(D3), 14, 7, 0);
    dev_en   = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      serial_in = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    dev_en   = 1'b1;
    send_range(enc(D3), 6, 0, 0);
    check("freeze_in_syndrome", syndrome, 0);
    check("freeze_in_valid", out_valid, 1);
    drain();

    // Enable freeze right after an errored load
    ec_cycles = 0;
    exp_q.push_back(D2);
    send_range(enc(D2) ^ (15'd1 << 10), 14, 0, 0);
    dev_en = 1'b0;
    repeat (5) tick();
    check("freeze_err_hold", err_corr, 1);
    check("freeze_syndrome", syndrome, 11);
    check("freeze_valid", out_valid, 1);
    check("freeze_first_bit", serial_out, D2[10]);
    dev_en = 1'b1;
    tick();
    check("freeze_err_release", err_corr, 0);
    drain();
    check("freeze_pulse_total", ec_cycles, 1);

    // Mid-frame reset discards partial and undelivered data
    out_en = 1'b0;
    send_range(enc(D1) ^ (15'd1 << 2), 14, 0, 0);
    check("pre_rst_syndrome", syndrome, 3);
    send_range(enc(D2), 14, 8, 0);
    rest = 1'b0;
    tick();
    check("mid_rst_serial_out", serial_out, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_err_corr", err_corr, 0);
    check("mid_rst_syndrome", syndrome, 0);
    check("mid_rst_overrun", overrun, 0);
    rest = 1'b1;
    out_en = 1'b1;
    exp_q.push_back(D3);
    send_range(enc(D3), 14, 0, 0);
    check("post_rst_syndrome", syndrome, 0);
    drain();

`ifdef HAMMING_ERR_CNT_EN
    // Saturating corrected-frame counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(D1);
      send_range(CW1 ^ (15'd1 << i), 14, 0, 0);
      check("err_cnt", err_cnt, (i < 2) ? i + 1 : 3);
      drain();
    end
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
